pulse_period_meter: RTL and testbench

//  Receive side of the divided-clock square wave (pulsex) generated on-board.

---
 rtl/pulse_period_meter.sv | 180 ++++++++++++++++++
 tb/tb_pulse_period_meter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pulse_period_meter.sv
// Purpose : measures period and high time of an async square wave in clk cycles, flags lock/timeout.
// Latency : rise detected 2 clk after pulsein is first sampled high (+FILT_LEN with GLITCH_FILTER_EN); strobe 1 clk later.
// Backpressure: none; period_valid is a one-cycle strobe that the consumer must take when it fires.
// Optional macro GLITCH_FILTER_EN enables the FILT_LEN-cycle glitch filter on the synchronised level.
module pulse_period_meter #(
  parameter int unsigned CPU_CLOCK   = 27_000_000,
  parameter int unsigned CNT_W       = 33,
  parameter int unsigned TIMEOUT_CYC = CPU_CLOCK / 5,
  parameter int unsigned TOL         = 2,
  parameter int unsigned FILT_LEN    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pulsein,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             period_valid,
  output logic             locked,
  output logic             timeout
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    MEASURE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W:0]   TOL_VAL = (CNT_W + 1)'(TOL);

  state_t           state;
  state_t           state_nxt;
  logic             sync1;
  logic             sync2;
  logic             lvl;
  logic             prev;
  logic             rise;
  logic             fall;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] hcnt;
  logic             fall_seen;
  logic [CNT_W:0]   diff;
  logic             lock_ok;
  logic             take;
  logic             arm;
  logic             to_hit;

  // Two-flop synchroniser for the asynchronous input.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= pulsein;
      sync2 <= sync1;
    end
  end

`ifdef GLITCH_FILTER_EN
  localparam int unsigned FC_W = (FILT_LEN > 1) ? $clog2(FILT_LEN + 1) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FILT_LEN - 1);

  logic            filt;
  logic [FC_W-1:0] fcnt;

  // Accept a new level only after FILT_LEN consecutive samples disagree with the held one.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt <= 1'b0;
      fcnt <= '0;
    end else if (sync2 == filt) begin
      fcnt <= '0;
    end else if (fcnt == FC_LAST) begin
      filt <= sync2;
      fcnt <= '0;
    end else begin
      fcnt <= fcnt + 1'b1;
    end
  end

  assign lvl = filt;
`else
  logic unused_filt_len;
  assign unused_filt_len = (FILT_LEN != 0);
  assign lvl = sync2;
`endif

  // Previous level register for edge detection.
  always_ff @(posedge clk) begin
    if (rst) prev <= 1'b0;
    else     prev <= lvl;
  end

  assign rise = lvl & ~prev;
  assign fall = ~lvl & prev;

  // Cycle counter since last rise: restarts at 1 on a rise, saturates at all-ones.
  always_comb begin
    cnt_nxt = cnt;
    if (rise)                cnt_nxt = CNT_W'(1);
    else if (cnt != CNT_MAX) cnt_nxt = cnt + 1'b1;
  end

  // Unsigned magnitude of (current period - previous period), one extra bit wide.
  always_comb begin
    diff = '0;
    if (cnt >= period) diff = {1'b0, cnt} - {1'b0, period};
    else               diff = {1'b0, period} - {1'b0, cnt};
  end

  assign lock_ok = (diff <= TOL_VAL);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and per-cycle controls; a rise takes priority over timeout.
  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    arm       = 1'b0;
    to_hit    = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          arm       = 1'b1;
          state_nxt = ARMED;
        end
      end
      ARMED, MEASURE: begin
        if (rise) begin
          take      = 1'b1;
          state_nxt = MEASURE;
        end else if (cnt_nxt >= TO_VAL) begin
          to_hit    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Counters, measurement registers and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      hcnt         <= '0;
      fall_seen    <= 1'b0;
      period       <= '0;
      high_time    <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      cnt          <= cnt_nxt;
      period_valid <= take;
      if (rise) begin
        fall_seen <= 1'b0;
      end else if (fall) begin
        fall_seen <= 1'b1;
        hcnt      <= cnt;
      end
      if (arm) timeout <= 1'b0;
      if (take) begin
        period    <= cnt;
        high_time <= fall_seen ? hcnt : '0;
        locked    <= lock_ok;
      end
      if (to_hit) begin
        timeout <= 1'b1;
        locked  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pulse_period_meter.sv
// Bench for pulse_period_meter: directed pulse trains, expected strobes queued by the
// stimulus and popped by an independent monitor; status flags checked at fixed cycles.
// Glitch expectations follow GLITCH_FILTER_EN when the bench is built with it.
module tb_pulse_period_meter;

  localparam int CW = 33;

  typedef struct {
    logic [CW-1:0] p;
    logic [CW-1:0] h;
    logic          lk;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          pulsein;
  logic [CW-1:0] period;
  logic [CW-1:0] high_time;
  logic          period_valid;
  logic          locked;
  logic          timeout;

  exp_t exp_q[$];
  exp_t e;
  int   errors;
  int   checks;
  logic pv_q;

  pulse_period_meter #(
    .CPU_CLOCK  (27_000_000),
    .CNT_W      (CW),
    .TIMEOUT_CYC(100),
    .TOL        (2),
    .FILT_LEN   (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pulsein     (pulsein),
    .period      (period),
    .high_time   (high_time),
    .period_valid(period_valid),
    .locked      (locked),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic hold(input logic v, input int n);
    pulsein = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic seg(input int h, input int l);
    hold(1'b1, h);
    hold(1'b0, l);
  endtask

  task automatic push(input int p, input int h, input logic lk);
    exp_t x;
    x.p  = CW'(p);
    x.h  = CW'(h);
    x.lk = lk;
    exp_q.push_back(x);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_period"}, period, '0);
    chk({tag, "_high_time"}, high_time, '0);
    chk({tag, "_period_valid"}, CW'(period_valid), '0);
    chk({tag, "_locked"}, CW'(locked), '0);
    chk({tag, "_timeout"}, CW'(timeout), '0);
  endtask

  // Monitor: every strobe pops one expected record; strobes must never be back to back.
  initial pv_q = 1'b0;
  always @(negedge clk) begin
    if (period_valid === 1'b1) begin
      chk("strobe_not_back_to_back", CW'(pv_q), '0);
      if (exp_q.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL unexpected_strobe: got period=%0d high_time=%0d, expected no strobe at %0t",
                 period, high_time, $time);
      end else begin
        e = exp_q.pop_front();
        chk("strobe_period", period, e.p);
        chk("strobe_high_time", high_time, e.h);
        chk("strobe_locked", CW'(locked), CW'(e.lk));
      end
    end
    pv_q = period_valid;
  end

  initial begin
    errors  = 0;
    checks  = 0;
    rst     = 1'b1;
    pulsein = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    hold(1'b0, 5);

    // Steady 20-cycle wave: no strobe on the first rise, lock on the second period.
    seg(10, 10);
    push(20, 10, 1'b0);
    seg(10, 10);
    push(20, 10, 1'b1);
    seg(10, 10);
    chk("locked_after_two_periods", CW'(locked), CW'(1));

    // Step from 20 to 26 cycles: lock drops on the first 26, returns on the second.
    push(20, 10, 1'b1);
    seg(13, 13);
    push(26, 13, 1'b0);
    seg(13, 13);
    push(26, 13, 1'b1);
    seg(13, 13);

    // Hold low after lock: timeout exactly when the counter reaches 100.
    push(26, 13, 1'b1);
    hold(1'b1, 13);
    hold(1'b0, 88);
    chk("timeout_not_yet", CW'(timeout), '0);
    hold(1'b0, 1);
    chk("timeout_set", CW'(timeout), CW'(1));
    chk("timeout_unlocks", CW'(locked), '0);
    chk("timeout_holds_period", period, CW'(26));
    chk("timeout_holds_high_time", high_time, CW'(13));
    hold(1'b0, 48);
    chk("timeout_sticky", CW'(timeout), CW'(1));
    hold(1'b1, 10);
    chk("rise_clears_timeout", CW'(timeout), '0);
    hold(1'b0, 10);
    push(20, 10, 1'b0);
    seg(10, 10);

    // Reset in the middle of a period discards everything.
    push(20, 10, 1'b1);
    hold(1'b1, 5);
    rst     = 1'b1;
    pulsein = 1'b0;
    @(negedge clk);
    check_zero("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    seg(10, 10);
    push(20, 10, 1'b0);
    seg(10, 10);
    hold(1'b0, 20);
    chk("one_strobe_after_reset", CW'(exp_q.size()), '0);

    // 2-cycle high glitch inside the low phase of a 20-cycle wave.
    rst = 1'b1;
    hold(1'b0, 3);
    rst = 1'b0;
    hold(1'b0, 3);
    seg(10, 10);
    push(20, 10, 1'b0);
    seg(10, 10);
    push(20, 10, 1'b1);
`ifndef GLITCH_FILTER_EN
    push(14, 10, 1'b0);
    push(6, 2, 1'b0);
`endif
    hold(1'b1, 10);
    hold(1'b0, 4);
    hold(1'b1, 2);
    hold(1'b0, 4);
`ifdef GLITCH_FILTER_EN
    push(20, 10, 1'b1);
`endif
    seg(10, 10);
`ifdef GLITCH_FILTER_EN
    push(20, 10, 1'b1);
`else
    push(20, 10, 1'b0);
`endif
    seg(10, 10);
    push(20, 10, 1'b1);
    seg(10, 30);
    chk("glitch_locked_final", CW'(locked), CW'(1));
    chk("all_strobes_seen", CW'(exp_q.size()), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
